cop_wb_queue: RTL and testbench

Write-back queue directly downstream of the Ascon ISE coprocessor. It captures each result the coprocessor asserts on its write-request output, with the destination register index, in a small in-order FIFO. It drains that FIFO into the core register-file write port whenever the port is granted. Its `cop_rdywr` output drives the coprocessor's `cop_rdywr` input, so a full queue stalls the coprocessor through `cop_ready`.

---
 rtl/cop_wb_queue.sv | 113 +++++++++++
 tb/tb_cop_wb_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_wb_queue.sv
// cop_wb_queue
//   In-order write-back queue between the Ascon ISE coprocessor and the core
//   register-file write port. Results with a nonzero destination index are
//   queued. Results addressed to x0 are accepted and thrown away. The head
//   entry is offered on rf_* and retires when the port is granted.
//
// Ports
//   cop_clk    in        clock, rising edge
//   cop_rst    in        asynchronous reset, active-low
//   cop_wr     in        coprocessor write request
//   cop_rd     in  [31:0] coprocessor result data
//   cop_rdidx  in  [4:0] destination register index
//   cop_rdywr  out       queue can accept this cycle (not full)
//   rf_wen     out       head entry valid, requesting the write port
//   rf_waddr   out [4:0] head entry register index (0 when empty)
//   rf_wdata   out [31:0] head entry data (0 when empty)
//   rf_gnt     in        write port granted; head retires
//   chk_idx    in  [4:0] scoreboard query index
//   chk_hit    out       a pending or incoming write targets chk_idx
//   count      out [AW:0] number of valid entries
//   drop_err   out       sticky: write presented while full
module cop_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          cop_clk,
  input  logic          cop_rst,
  input  logic          cop_wr,
  input  logic [31:0]   cop_rd,
  input  logic [4:0]    cop_rdidx,
  output logic          cop_rdywr,
  output logic          rf_wen,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  input  logic          rf_gnt,
  input  logic [4:0]    chk_idx,
  output logic          chk_hit,
  output logic [AW:0]   count,
  output logic          drop_err
);

  localparam int DATA_W = 32;

  logic [4:0]        idx_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [AW-1:0]     rp;
  logic [AW-1:0]     wp;

  logic full;
  logic empty;
  logic push_wr;
  logic pop;
  logic hit_any;
  logic [AW-1:0] off;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cop_rdywr = ~full;
  // Only nonzero indices occupy a slot; x0 writes are accepted and dropped.
  assign push_wr   = cop_wr & cop_rdywr & (cop_rdidx != 5'd0);
  assign pop       = rf_wen & rf_gnt;

  assign rf_wen   = ~empty;
  assign rf_waddr = empty ? 5'd0 : idx_q[rp];
  assign rf_wdata = empty ? '0   : data_q[rp];

  // Entry i is live when its distance from rp is below count; pointer
  // arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    hit_any = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rp;
      if (({1'b0, off} < count) && (idx_q[i] == chk_idx)) begin
        hit_any = 1'b1;
      end
    end
    chk_hit = (chk_idx != 5'd0) &&
              (hit_any || (push_wr && (cop_rdidx == chk_idx)));
  end

  // Queue state register stage
  always_ff @(posedge cop_clk or negedge cop_rst) begin
    if (!cop_rst) begin
      rp       <= '0;
      wp       <= '0;
      count    <= '0;
      drop_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i]  <= 5'd0;
        data_q[i] <= '0;
      end
    end else begin
      if (push_wr) begin
        idx_q[wp]  <= cop_rdidx;
        data_q[wp] <= cop_rd;
        wp         <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      case ({push_wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (cop_wr && full) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cop_wb_queue.sv
module tb_cop_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          cop_clk;
  logic          cop_rst;
  logic          cop_wr;
  logic [31:0]   cop_rd;
  logic [4:0]    cop_rdidx;
  logic          cop_rdywr;
  logic          rf_wen;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          rf_gnt;
  logic [4:0]    chk_idx;
  logic          chk_hit;
  logic [AW:0]   count;
  logic          drop_err;

  int checks;
  int failures;

  // Reference model: queue of {idx, data} plus the sticky drop flag.
  logic [36:0] mq[$];
  bit          mdrop;

  cop_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .cop_clk   (cop_clk),
    .cop_rst   (cop_rst),
    .cop_wr    (cop_wr),
    .cop_rd    (cop_rd),
    .cop_rdidx (cop_rdidx),
    .cop_rdywr (cop_rdywr),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_gnt    (rf_gnt),
    .chk_idx   (chk_idx),
    .chk_hit   (chk_hit),
    .count     (count),
    .drop_err  (drop_err)
  );

  initial cop_clk = 1'b0;
  always #5 cop_clk = ~cop_clk;

  // Advance one clock; the model consumes the inputs presented before the edge.
  task automatic cycle();
    bit          full;
    bit          do_pop;
    bit          do_push;
    bit          do_drop;
    logic [36:0] ent;
    full    = (mq.size() == DEPTH);
    do_pop  = (mq.size() > 0) && rf_gnt;
    do_push = cop_wr && !full && (cop_rdidx != 5'd0);
    do_drop = cop_wr && full;
    ent     = {cop_rdidx, cop_rd};
    @(posedge cop_clk);
    #1;
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(ent);
    if (do_drop) mdrop = 1'b1;
  endtask

  task automatic idle_inputs();
    cop_wr    = 1'b0;
    cop_rd    = 32'd0;
    cop_rdidx = 5'd0;
    rf_gnt    = 1'b0;
    chk_idx   = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cop_rst = 1'b0;
    repeat (2) @(posedge cop_clk);
    @(negedge cop_clk);
    cop_rst = 1'b1;
    mq.delete();
    mdrop = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cop_rst = 1'b0;
    mq.delete();
    mdrop = 1'b0;
    chk_idx = 5'd5;
    #7;
    checks++; if (rf_wen !== 1'b0)    begin failures++; $display("FAIL reset_rf_wen got=%0b exp=0", rf_wen); end
    checks++; if (rf_waddr !== 5'd0)  begin failures++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (cop_rdywr !== 1'b1) begin failures++; $display("FAIL reset_rdywr got=%0b exp=1", cop_rdywr); end
    checks++; if (chk_hit !== 1'b0)   begin failures++; $display("FAIL reset_chk_hit got=%0b exp=0", chk_hit); end
    checks++; if (drop_err !== 1'b0)  begin failures++; $display("FAIL reset_drop_err got=%0b exp=0", drop_err); end
    do_reset();
  endtask

  task automatic test_single();
    cop_wr = 1'b1; cop_rdidx = 5'd5; cop_rd = 32'hDEADBEEF; rf_gnt = 1'b0;
    cycle();
    cop_wr = 1'b0;
    checks++; if (rf_wen !== 1'b1)          begin failures++; $display("FAIL single_rf_wen got=%0b exp=1", rf_wen); end
    checks++; if (rf_waddr !== 5'd5)        begin failures++; $display("FAIL single_rf_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rf_wdata got=%h exp=deadbeef", rf_wdata); end
    checks++; if (count !== 3'd1)           begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    rf_gnt = 1'b1;
    cycle();
    rf_gnt = 1'b0;
    checks++; if (count !== 3'd0)  begin failures++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL single_pop_rf_wen got=%0b exp=0", rf_wen); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      cop_wr = 1'b1; cop_rdidx = 5'(i); cop_rd = 32'h11 * i;
      cycle();
    end
    cop_wr = 1'b0;
    checks++; if (cop_rdywr !== 1'b0) begin failures++; $display("FAIL fill_rdywr got=%0b exp=0", cop_rdywr); end
    checks++; if (count !== 3'd4)     begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    cop_wr = 1'b1; cop_rdidx = 5'd6; cop_rd = 32'h55;
    cycle();
    cop_wr = 1'b0;
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL fill_drop_err got=%0b exp=1", drop_err); end
    checks++; if (count !== 3'd4)    begin failures++; $display("FAIL fill_drop_count got=%0d exp=4", count); end
    rf_gnt = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (rf_waddr !== 5'(k) || rf_wdata !== 32'h11 * k) begin
        failures++;
        $display("FAIL drain_order got=%0d/%h exp=%0d/%h", rf_waddr, rf_wdata, k, 32'h11 * k);
      end
      cycle();
    end
    rf_gnt = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    rf_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cop_wr = 1'b1; cop_rdidx = 5'd7; cop_rd = 32'h100 + k;
      cycle();
      checks++;
      if (count !== 3'd1 || rf_wdata !== 32'h100 + k) begin
        failures++;
        $display("FAIL b2b_step%0d got=count %0d data %h exp=count 1 data %h", k, count, rf_wdata, 32'h100 + k);
      end
    end
    cop_wr = 1'b0;
    cycle();
    rf_gnt = 1'b0;
    checks++; if (count !== 3'd0)    begin failures++; $display("FAIL b2b_end_count got=%0d exp=0", count); end
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL b2b_drop_err got=%0b exp=0", drop_err); end
  endtask

  task automatic test_x0_discard();
    cop_wr = 1'b1; cop_rdidx = 5'd0; cop_rd = 32'h1234; chk_idx = 5'd0;
    #1;
    checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL x0_chk_hit got=%0b exp=0", chk_hit); end
    cycle();
    cop_wr = 1'b0;
    checks++; if (cop_rdywr !== 1'b1) begin failures++; $display("FAIL x0_rdywr got=%0b exp=1", cop_rdywr); end
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL x0_count got=%0d exp=0", count); end
    checks++; if (rf_wen !== 1'b0)    begin failures++; $display("FAIL x0_rf_wen got=%0b exp=0", rf_wen); end
  endtask

  task automatic test_hazard();
    cop_wr = 1'b1; cop_rdidx = 5'd3; cop_rd = $urandom;
    cycle();
    cop_rdidx = 5'd9; cop_rd = $urandom;
    cycle();
    cop_wr = 1'b0;
    chk_idx = 5'd9; #1;
    checks++; if (chk_hit !== 1'b1) begin failures++; $display("FAIL hazard_hit9 got=%0b exp=1", chk_hit); end
    chk_idx = 5'd4; #1;
    checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL hazard_miss4 got=%0b exp=0", chk_hit); end
    cop_wr = 1'b1; cop_rdidx = 5'd4; cop_rd = $urandom; #1;
    checks++; if (chk_hit !== 1'b1) begin failures++; $display("FAIL hazard_same_cycle got=%0b exp=1", chk_hit); end
    cycle();
    cop_wr = 1'b0;
    chk_idx = 5'd0;
  endtask

  task automatic test_async_reset();
    // Fill to 4, provoke a drop, retire one: 3 pending with drop_err set.
    cop_wr = 1'b1; cop_rdidx = 5'd8; cop_rd = 32'hA5A5;
    cycle();
    cycle();
    cop_wr = 1'b0; rf_gnt = 1'b1;
    cycle();
    rf_gnt = 1'b0;
    checks++;
    if (count !== 3'd3 || drop_err !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got=count %0d drop %0b exp=count 3 drop 1", count, drop_err);
    end
    #3;
    cop_rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
    checks++; if (rf_wen !== 1'b0)    begin failures++; $display("FAIL arst_rf_wen got=%0b exp=0", rf_wen); end
    checks++; if (drop_err !== 1'b0)  begin failures++; $display("FAIL arst_drop_err got=%0b exp=0", drop_err); end
    checks++; if (cop_rdywr !== 1'b1) begin failures++; $display("FAIL arst_rdywr got=%0b exp=1", cop_rdywr); end
    do_reset();
  endtask

  task automatic test_random();
    bit          m_hit;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    for (int n = 0; n < 300; n++) begin
      cop_wr    = ($urandom_range(0, 3) != 0);
      cop_rdidx = 5'($urandom_range(0, 7));
      cop_rd    = $urandom;
      rf_gnt    = $urandom_range(0, 1);
      chk_idx   = 5'($urandom_range(0, 7));
      #1;
      m_hit = 1'b0;
      foreach (mq[j]) if (mq[j][36:32] == chk_idx) m_hit = 1'b1;
      if (cop_wr && mq.size() < DEPTH && cop_rdidx != 5'd0 && cop_rdidx == chk_idx) m_hit = 1'b1;
      if (chk_idx == 5'd0) m_hit = 1'b0;
      checks++; if (chk_hit !== m_hit) begin failures++; $display("FAIL rnd_chk_hit n=%0d got=%0b exp=%0b", n, chk_hit, m_hit); end
      cycle();
      exp_addr = (mq.size() > 0) ? mq[0][36:32] : 5'd0;
      exp_data = (mq.size() > 0) ? mq[0][31:0]  : 32'd0;
      checks++; if (count !== 3'(mq.size()))          begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, mq.size()); end
      checks++; if (rf_wen !== (mq.size() > 0))       begin failures++; $display("FAIL rnd_rf_wen n=%0d got=%0b", n, rf_wen); end
      checks++; if (rf_waddr !== exp_addr)            begin failures++; $display("FAIL rnd_rf_waddr n=%0d got=%0d exp=%0d", n, rf_waddr, exp_addr); end
      checks++; if (rf_wdata !== exp_data)            begin failures++; $display("FAIL rnd_rf_wdata n=%0d got=%h exp=%h", n, rf_wdata, exp_data); end
      checks++; if (cop_rdywr !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_rdywr n=%0d got=%0b", n, cop_rdywr); end
      checks++; if (drop_err !== mdrop)               begin failures++; $display("FAIL rnd_drop_err n=%0d got=%0b exp=%0b", n, drop_err, mdrop); end
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_x0_discard();
    test_hazard();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
